alu_result_stage: RTL and testbench

- Sits directly downstream of the 16-bit ALU (x, y, alu_op, mode, c_in -> z, c_out).
- Captures each ALU result, derives the C/Z/N/V flags, holds results in a 2-entry skid buffer with a valid/ready handshake toward register-file writeback, and keeps an architectural flag register.
- The C flag feeds back to the ALU c_in for chained multi-word arithmetic.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_flag_gen.sv | 37 +++
 rtl/alu_result_stage.sv | 107 ++++++++++
 tb/tb_alu_result_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: opcode encodings, flag bit positions, default datapath width.
package alu_pkg;
  localparam int ALU_W = 16;

  localparam logic [3:0] ALU_OP_ADD = 4'b1001;
  localparam logic [3:0] ALU_OP_SUB = 4'b0110;

  // Position of each flag inside the {C,Z,N,V} flag word.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_flag_gen.sv
// Combinational C/Z/N/V derivation for one ALU result given the previous flag word.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic [WIDTH-1:0] z,
  input  logic             c_out,
  input  logic             x_msb,
  input  logic             y_msb,
  input  logic [3:0]       alu_op,
  input  logic             mode,
  input  logic             chain,
  input  logic [3:0]       flags_prev,
  output logic [3:0]       flags_nxt
);
  logic z_zero;
  logic z_msb;

  assign z_zero = (z == '0);
  assign z_msb  = z[WIDTH-1];

  always_comb begin
    flags_nxt         = flags_prev;
    flags_nxt[FLAG_N] = z_msb;
    // Chained words only report zero if every word so far was zero.
    flags_nxt[FLAG_Z] = chain ? (flags_prev[FLAG_Z] & z_zero) : z_zero;
    if (!mode) begin
      flags_nxt[FLAG_C] = c_out;
      flags_nxt[FLAG_V] = 1'b0;
      if (alu_op == ALU_OP_ADD)
        flags_nxt[FLAG_V] = (x_msb == y_msb) & (z_msb != x_msb);
      else if (alu_op == ALU_OP_SUB)
        flags_nxt[FLAG_V] = (x_msb != y_msb) & (z_msb != x_msb);
    end
  end
endmodule

// File: rtl/alu_result_stage.sv
// ALU result capture: 2-entry skid buffer toward writeback plus the architectural flag register.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_W,
  parameter int DEST_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  z,
  input  logic              c_out,
  input  logic              x_msb,
  input  logic              y_msb,
  input  logic [3:0]        alu_op,
  input  logic              mode,
  input  logic [DEST_W-1:0] dest,
  input  logic              flag_we,
  input  logic              chain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags,
  output logic              c_flag
);
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert immediately with reset_n, release two clocks later in this domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0][WIDTH-1:0]  data_q,  data_d;
  logic [1:0][DEST_W-1:0] dst_q,   dst_d;
  logic [1:0]             count_q, count_d;
  logic                   head_q,  head_d;
  logic                   tail_q,  tail_d;
  logic [3:0]             flags_q, flags_d;
  logic [3:0]             flags_nxt;
  logic                   push, pop;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .z          (z),
    .c_out      (c_out),
    .x_msb      (x_msb),
    .y_msb      (y_msb),
    .alu_op     (alu_op),
    .mode       (mode),
    .chain      (chain),
    .flags_prev (flags_q),
    .flags_nxt  (flags_nxt)
  );

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    data_d  = data_q;
    dst_d   = dst_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    flags_d = flags_q;
    if (push) begin
      data_d[tail_q] = z;
      dst_d[tail_q]  = dest;
      tail_d         = ~tail_q;
      if (flag_we) flags_d = flags_nxt;
    end
    if (pop) head_d = ~head_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      dst_q   <= '0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
      flags_q <= 4'b0000;
    end else begin
      data_q  <= data_d;
      dst_q   <= dst_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign out_data = data_q[head_q];
  assign out_dest = dst_q[head_q];
  assign flags    = flags_q;
  assign c_flag   = flags_q[FLAG_C];
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench: stimulus pushes expected writebacks to a queue, a negedge monitor pops and compares.
module tb_alu_result_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] z = '0;
  logic        c_out = 1'b0, x_msb = 1'b0, y_msb = 1'b0;
  logic [3:0]  alu_op = '0;
  logic        mode = 1'b0;
  logic [2:0]  dest = '0;
  logic        flag_we = 1'b0, chain = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [2:0]  out_dest;
  logic [3:0]  flags;
  logic        c_flag;

  int pass_cnt = 0;
  int tot_cnt  = 0;
  logic [18:0] exp_q[$];

  alu_result_stage #(.WIDTH(16), .DEST_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .z(z), .c_out(c_out), .x_msb(x_msb), .y_msb(y_msb), .alu_op(alu_op),
    .mode(mode), .dest(dest), .flag_we(flag_we), .chain(chain),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dest(out_dest), .flags(flags), .c_flag(c_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Monitor: a writeback completes at the next posedge when valid & ready here.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tot_cnt++;
        $display("FAIL unexpected_out: got %h with empty scoreboard", out_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        chk("out_data", {16'h0, out_data}, {16'h0, e[18:3]});
        chk("out_dest", {29'h0, out_dest}, {29'h0, e[2:0]});
      end
    end
  end

  // Called in the posedge+1 phase; returns in the posedge+1 phase after the accept edge.
  task automatic accept(input logic [15:0] zv, input logic co, input logic xm, input logic ym,
                        input logic [3:0] op, input logic md, input logic [2:0] dst,
                        input logic fwe, input logic ch);
    int n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      tot_cnt++;
      $display("FAIL accept_timeout: in_ready stuck at %b want 1", in_ready);
      return;
    end
    z = zv; c_out = co; x_msb = xm; y_msb = ym; alu_op = op; mode = md;
    dest = dst; flag_we = fwe; chain = ch; in_valid = 1'b1;
    exp_q.push_back({zv, dst});
    @(posedge clk); #1;
    in_valid = 1'b0; flag_we = 1'b0; chain = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with in_valid asserted
    reset_n = 1'b0; in_valid = 1'b1; z = 16'hBEEF; flag_we = 1'b1;
    cycles(3);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'h0, in_ready},  32'd1);
    chk("rst_flags",     {28'h0, flags},     32'h0);
    chk("rst_out_data",  {16'h0, out_data},  32'h0);
    chk("rst_out_dest",  {29'h0, out_dest},  32'h0);
    in_valid = 1'b0; flag_we = 1'b0;
    reset_n = 1'b1;
    cycles(4);

    // First accept: one-cycle latency
    chk("pre_out_valid", {31'h0, out_valid}, 32'd0);
    accept(16'h1234, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd5, 1'b1, 1'b0);
    chk("lat_out_valid", {31'h0, out_valid}, 32'd1);
    chk("lat_out_data",  {16'h0, out_data},  32'h1234);
    chk("flags_first",   {28'h0, flags},     32'h0);

    accept(16'h8000, 1'b0, 1'b0, 1'b0, ALU_OP_ADD, 1'b0, 3'd1, 1'b1, 1'b0);
    chk("add_ovf", {28'h0, flags}, 32'b0011);
    accept(16'h0000, 1'b1, 1'b1, 1'b1, ALU_OP_SUB, 1'b0, 3'd2, 1'b1, 1'b0);
    chk("sub_zero_borrow", {28'h0, flags}, 32'b1100);
    chk("c_flag_sub", {31'h0, c_flag}, 32'd1);
    accept(16'h8000, 1'b0, 1'b0, 1'b1, ALU_OP_SUB, 1'b0, 3'd3, 1'b1, 1'b0);
    chk("sub_ovf", {28'h0, flags}, 32'b0011);
    accept(16'h0000, 1'b1, 1'b1, 1'b1, ALU_OP_ADD, 1'b0, 3'd4, 1'b1, 1'b0);
    chk("add_carry_ovf", {28'h0, flags}, 32'b1101);
    accept(16'hFFFF, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd6, 1'b1, 1'b0);
    chk("logic_preserve", {28'h0, flags}, 32'b1011);
    accept(16'h0000, 1'b0, 1'b0, 1'b0, ALU_OP_ADD, 1'b0, 3'd7, 1'b0, 1'b0);
    chk("no_flag_we", {28'h0, flags}, 32'b1011);

    // Chained zero detection across three words
    accept(16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd0, 1'b1, 1'b0);
    chk("chain_w0", {28'h0, flags}, 32'b1101);
    accept(16'h0001, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd1, 1'b1, 1'b1);
    chk("chain_w1", {28'h0, flags}, 32'b1001);
    accept(16'h0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 3'd2, 1'b1, 1'b1);
    chk("chain_w2", {28'h0, flags}, 32'b1001);
    accept(16'h8000, 1'b0, 1'b0, 1'b0, 4'h3, 1'b0, 3'd3, 1'b1, 1'b0);
    chk("other_op_v0", {28'h0, flags}, 32'b0010);
    cycles(3);

    // Backpressure: fill, drop extra inputs, then drain in order
    out_ready = 1'b0;
    accept(16'h0001, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd1, 1'b0, 1'b0);
    accept(16'h0002, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'd2, 1'b0, 1'b0);
    chk("full_in_ready",  {31'h0, in_ready},  32'd0);
    chk("full_out_valid", {31'h0, out_valid}, 32'd1);
    chk("full_head",      {16'h0, out_data},  32'h0001);
    z = 16'hDEAD; c_out = 1'b1; alu_op = ALU_OP_ADD; mode = 1'b0;
    flag_we = 1'b1; in_valid = 1'b1;
    cycles(2);
    in_valid = 1'b0; flag_we = 1'b0;
    chk("drop_flags", {28'h0, flags}, 32'b0010);
    chk("drop_head",  {16'h0, out_data}, 32'h0001);
    out_ready = 1'b1;
    cycles(1);
    chk("pop1_in_ready",  {31'h0, in_ready},  32'd1);
    chk("pop1_out_valid", {31'h0, out_valid}, 32'd1);
    chk("pop1_head",      {16'h0, out_data},  32'h0002);
    cycles(2);

    // Pointer wrap over ten entries with intermittent backpressure
    for (int i = 0; i < 10; i++) begin
      out_ready = (i % 3 != 0);
      accept(16'h0100 + 16'(i), 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 3'(i), 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycles(1);
    chk("wrap_drained", exp_q.size(), 32'd0);

    // Reset while entries are buffered
    out_ready = 1'b0;
    accept(16'h00AA, 1'b0, 1'b0, 1'b0, ALU_OP_ADD, 1'b0, 3'd1, 1'b1, 1'b0);
    accept(16'h8000, 1'b0, 1'b0, 1'b0, ALU_OP_ADD, 1'b0, 3'd2, 1'b1, 1'b0);
    chk("pre_rst_flags", {28'h0, flags}, 32'b0011);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'd0);
    chk("midrst_in_ready",  {31'h0, in_ready},  32'd1);
    chk("midrst_flags",     {28'h0, flags},     32'h0);
    exp_q.delete();
    out_ready = 1'b1;
    cycles(2);
    reset_n = 1'b1;
    cycles(4);
    chk("post_rst_out_valid", {31'h0, out_valid}, 32'd0);
    accept(16'h1234, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 3'd4, 1'b1, 1'b0);
    chk("post_rst_flags", {28'h0, flags}, 32'b1000);
    for (int n = 0; n < 10 && exp_q.size() != 0; n++) cycles(1);
    chk("final_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
